// File: rtl/deser_1x8.sv
// 1-to-8 deserializer: a 3-bit bit-index counter steers each valid serial bit into an
// assembly register. Completed words move to a holding register with a valid/ready handshake.
// A sticky overrun flag records any completed word that had to be dropped.
module deser_1x8 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       din_i,
  input  logic       din_valid_i,
  input  logic       sof_i,
  output logic [7:0] dout_o,
  output logic       dout_valid_o,
  input  logic       dout_ready_i,
  output logic [2:0] bit_idx_o,
  output logic       overrun_o
);

  logic [7:0] asm_q, asm_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overrun_q, overrun_d;
  logic [2:0] bit_idx_q, bit_idx_d;

  logic [2:0] eff_idx;
  logic [2:0] pos;
  logic [7:0] word;
  logic       complete;
  logic       accept;

  // Bit steering: sof forces index 0, and the current bit is merged into the word immediately.
  always_comb begin
    eff_idx     = (sof_i && din_valid_i) ? 3'd0 : bit_idx_q;
    pos         = LSB_FIRST ? eff_idx : (3'd7 - eff_idx);
    word        = asm_q;
    word[pos]   = din_i;
    complete    = din_valid_i && (eff_idx == 3'd7);
    accept      = dout_valid_q && dout_ready_i;
  end

  // Next-state for the assembly register, the counter and the holding register.
  always_comb begin
    asm_d        = asm_q;
    bit_idx_d    = bit_idx_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;

    if (din_valid_i) begin
      asm_d     = word;
      bit_idx_d = eff_idx + 3'd1;
    end

    if (complete && (!dout_valid_q || accept)) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
    end else if (complete) begin
      // Holding register still owned by the consumer: drop the new word.
      overrun_d = 1'b1;
    end else if (accept) begin
      dout_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      asm_q        <= 8'h00;
      bit_idx_q    <= 3'd0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      bit_idx_q    <= bit_idx_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign bit_idx_o    = bit_idx_q;
  assign overrun_o    = overrun_q;

endmodule

// File: doc/deser_1x8.md
# deser_1x8

Serial-to-parallel deserializer that reassembles 8-bit words from a 1-bit stream, one bit per valid cycle. It is the receive-side counterpart of the 8:1 mux tree driven by a 3-bit select counter. A 3-bit bit-index counter plays the role of the select lines, routing each incoming bit to one of eight positions in the word. Completed words go to a holding register with a valid/ready handshake; a sticky flag reports overruns.

## Interface
- LSB_FIRST, 1, 1: first bit of a frame lands in dout[0]. 0: first bit lands in dout[7].
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- din  input  1  serial data bit
- din_valid  input  1  din is sampled this cycle
- sof  input  1  start of frame; sampled only when din_valid=1
- dout  output  8  assembled word (holding register)
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- bit_idx  output  3  index of the next bit to be captured (0..7)
- overrun  output  1  sticky; a completed word was dropped

## Operation
- Reset: synchronous, active-high, on clk edge with rst=1. Clears dout=8'h00, dout_valid=0, bit_idx=0, overrun=0 and the assembly register. rst has priority over all other inputs, including mid-frame; any partial frame is discarded.
- Bit placement: effective index e = (sof & din_valid) ? 0 : bit_idx. Position p = LSB_FIRST ? e : 7-e. On din_valid=1, assembly[p] <= din.
- Counter:
  - din_valid=1: bit_idx <= e+1 mod 8.
  - din_valid=0: bit_idx holds. Gaps of any length between bits are legal.
- sof with din_valid=1: abandons any partial frame, and the current bit is bit 0 of a new frame. With bit_idx already 0, sof has no extra effect. sof with din_valid=0 is ignored.
- Frame completion: a cycle with din_valid=1 and e=7. The completed word is the assembly register with the current bit merged in; it is not delayed by one cycle.
- Holding register / handshake:
  - Accept event: dout_valid & dout_ready.
  - Completion and (dout_valid=0 or accept): dout <= word, dout_valid <= 1.
  - Accept without completion: dout_valid <= 0, dout holds its old value.
  - Completion while dout_valid=1 and dout_ready=0: the new word is dropped, dout keeps the old word, and overrun <= 1.
- overrun stays 1 until rst.
- Unwritten assembly bits retain stale values. They are always overwritten before completion unless a sof occurs, and a sof restarts the frame at bit 0.

## Timing
- Latency: last bit sampled on edge k; dout and dout_valid are updated on edge k and visible in the following cycle.
- Throughput: one word per 8 valid cycles. With dout_ready=1, back-to-back frames never overrun.
- dout_ready is ignored while dout_valid=0.
- dout and dout_valid depend only on registers; there is no combinational path from din, din_valid or sof to the outputs.
- bit_idx is registered and reflects the position for the next valid bit.

## Test plan
- Basic frame, LSB_FIRST=1, dout_ready=1:
  - Stimulus: bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles, sof on the first.
  - Response: dout=8'hA5 and dout_valid=1 for exactly one cycle after the 8th bit. bit_idx reads 1,2,…,7,0.
- Gapped input:
  - Stimulus: same frame as the basic case, with din_valid=0 for 3 cycles between each bit.
  - Response: identical dout=8'hA5. bit_idx holds during the gaps.
  - Repeat with LSB_FIRST=0: dout=8'hA5 for bit order 1,0,1,0,0,1,0,1 MSB first.
- Resync:
  - Stimulus: send 5 bits, then sof with a new frame 0,1,1,1,1,0,0,0 (LSB first).
  - Response: dout=8'h1E. No word is emitted for the aborted partial frame. overrun=0.
- Backpressure/overrun:
  - Stimulus: dout_ready=0; send frames 8'h3C then 8'hC3.
  - Response: dout stays 8'h3C with dout_valid=1; overrun=1 after the second completion.
  - Then raise dout_ready for one cycle: dout_valid=0 next cycle, and overrun stays 1.
- Simultaneous accept and complete:
  - Stimulus: hold dout_ready=0 after frame 8'h55 completes. Assert dout_ready in exactly the cycle the 8th bit of 8'hAA arrives.
  - Response: dout=8'hAA, dout_valid=1, overrun=0.
- Reset mid-operation:
  - Stimulus: rst for one cycle after 4 bits, with dout_valid=1 and overrun=1 set.
  - Response: all outputs 0 next cycle. A following full frame 8'h0F is then received correctly.
